// File: rtl/fhn_spike_encoder.sv
// Spike encoder for the FHN neuron core: hysteresis threshold FSM with refractory hold,
// queuing {onset timestamp, peak v} events into an 8-deep first-word-fall-through FIFO.
module fhn_spike_encoder #(
    parameter int                         DATA_W   = 16,
    parameter int                         FRC_BITS = 12,
    parameter int                         TS_W     = 32,
    parameter int                         FIFO_AW  = 3,
    parameter logic signed [DATA_W-1:0]   THR_HI   = 16'sd2048,
    parameter logic signed [DATA_W-1:0]   THR_LO   = -16'sd2048,
    parameter int                         REFRAC   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] v_in,
    input  logic                     ts_clear,
    input  logic                     spk_ready,
    output logic                     spk_valid,
    output logic [TS_W-1:0]          spk_ts,
    output logic signed [DATA_W-1:0] spk_peak,
    output logic                     spike_pulse,
    output logic [FIFO_AW:0]         fifo_count,
    output logic                     overflow,
    input  logic                     ovf_clear
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int RC_W  = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;

    localparam logic [1:0] ST_REARM   = 2'd0;
    localparam logic [1:0] ST_QUIET   = 2'd1;
    localparam logic [1:0] ST_SPIKING = 2'd2;
    localparam logic [1:0] ST_REFRACT = 2'd3;

    if (FRC_BITS >= DATA_W || THR_LO >= THR_HI) begin : g_param_check
        $error("fhn_spike_encoder: bad FRC_BITS or threshold ordering");
    end

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] peak;
    } entry_t;

    logic [1:0]                state;
    logic [TS_W-1:0]           ts;
    logic [TS_W-1:0]           onset_ts;
    logic signed [DATA_W-1:0]  peak;
    logic [RC_W-1:0]           refrac_cnt;

    logic v_hi, v_lo, push, pop, full, wr_ok;

    assign v_hi = (v_in >= THR_HI);
    assign v_lo = (v_in <= THR_LO);
    // The release sample only closes the event; it never competes for the peak.
    assign push = en && (state == ST_SPIKING) && v_lo;

    // NOTE: every register below uses non-blocking assignment so all state updates
    // see the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts <= '0;
        end else if (ts_clear) begin
            ts <= '0;
        end else if (en) begin
            ts <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_REARM;
            onset_ts    <= '0;
            peak        <= '0;
            refrac_cnt  <= '0;
            spike_pulse <= 1'b0;
        end else begin
            spike_pulse <= 1'b0;
            if (en) begin
                case (state)
                    ST_REARM: begin
                        if (v_lo) state <= ST_QUIET;
                    end
                    ST_QUIET: begin
                        if (v_hi) begin
                            state       <= ST_SPIKING;
                            onset_ts    <= ts;
                            peak        <= v_in;
                            spike_pulse <= 1'b1;
                        end
                    end
                    ST_SPIKING: begin
                        if (v_lo) begin
                            if (REFRAC > 0) begin
                                state      <= ST_REFRACT;
                                refrac_cnt <= RC_W'(REFRAC);
                            end else begin
                                state <= ST_QUIET;
                            end
                        end else if (v_in > peak) begin
                            peak <= v_in;
                        end
                    end
                    ST_REFRACT: begin
                        if (refrac_cnt == RC_W'(1)) state <= ST_QUIET;
                        else                        refrac_cnt <= refrac_cnt - 1'b1;
                    end
                    default: state <= ST_REARM;
                endcase
            end
        end
    end

    // Event FIFO
    entry_t              mem [DEPTH];
    entry_t              head;
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    count;

    assign full      = (count == (FIFO_AW + 1)'(DEPTH));
    assign spk_valid = (count != '0);
    assign pop       = spk_valid && spk_ready;
    assign wr_ok     = push && (!full || pop);

    // NOTE: storage is deliberately left unreset; the read port is masked while
    // empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= '{ts: onset_ts, peak: peak};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !pop)      count <= count + 1'b1;
            else if (!wr_ok && pop) count <= count - 1'b1;
            // A drop in the same cycle as a clear request must stay visible.
            if (push && full && !pop) overflow <= 1'b1;
            else if (ovf_clear)       overflow <= 1'b0;
        end
    end

    // NOTE: the output mux is fully assigned in every branch, so no latch is inferred.
    always_comb begin
        head     = mem[rd_ptr];
        spk_ts   = '0;
        spk_peak = '0;
        if (spk_valid) begin
            spk_ts   = head.ts;
            spk_peak = $signed(head.peak);
        end
    end

    assign fifo_count = count;

endmodule

// File: tb/tb_fhn_spike_encoder.sv
// Self-checking bench for fhn_spike_encoder: directed scenarios plus randomized traffic,
// compared every cycle against an event-level reference model.
module tb_fhn_spike_encoder;

    localparam int DATA_W = 16;
    localparam int TS_W   = 32;
    localparam int REFRAC = 16;
    localparam int HI     = 2048;
    localparam int LO     = -2048;

    logic                     clk = 1'b0;
    logic                     rst, en, ts_clear, spk_ready, ovf_clear;
    logic signed [DATA_W-1:0] v_in;

    logic                     spk_valid, spike_pulse, overflow;
    logic [TS_W-1:0]          spk_ts;
    logic signed [DATA_W-1:0] spk_peak;
    logic [3:0]               fifo_count;

    logic                     spk_valid8, spike_pulse8, overflow8;
    logic [7:0]               spk_ts8;
    logic signed [DATA_W-1:0] spk_peak8;
    logic [3:0]               fifo_count8;

    always #5 clk = ~clk;

    fhn_spike_encoder #(.TS_W(TS_W), .REFRAC(REFRAC)) dut (
        .clk(clk), .rst(rst), .en(en), .v_in(v_in), .ts_clear(ts_clear),
        .spk_ready(spk_ready), .spk_valid(spk_valid), .spk_ts(spk_ts),
        .spk_peak(spk_peak), .spike_pulse(spike_pulse), .fifo_count(fifo_count),
        .overflow(overflow), .ovf_clear(ovf_clear)
    );

    fhn_spike_encoder #(.TS_W(8), .REFRAC(REFRAC)) dut8 (
        .clk(clk), .rst(rst), .en(en), .v_in(v_in), .ts_clear(ts_clear),
        .spk_ready(spk_ready), .spk_valid(spk_valid8), .spk_ts(spk_ts8),
        .spk_peak(spk_peak8), .spike_pulse(spike_pulse8), .fifo_count(fifo_count8),
        .overflow(overflow8), .ovf_clear(ovf_clear)
    );

    // Reference model: event-level view of the encoder
    typedef struct {
        longint ts;
        int     peak;
    } ev_t;

    ev_t    q[$];
    longint m_ts;
    bit     m_armed, m_spiking, m_pulse, m_ovf;
    int     m_refr_left;
    longint m_onset;
    int     m_peak;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_count;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts        = 0;
        m_armed     = 0;
        m_spiking   = 0;
        m_pulse     = 0;
        m_ovf       = 0;
        m_refr_left = 0;
        m_onset     = 0;
        m_peak      = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit  pop, push, full;
        ev_t e;
        int  v;
        v     = int'(v_in);
        pop   = (q.size() > 0) && spk_ready;
        full  = (q.size() == 8);
        push  = 0;
        e     = '{ts: 0, peak: 0};
        m_pulse = 0;
        if (en) begin
            if (!m_armed) begin
                if (v <= LO) m_armed = 1;
            end else if (m_refr_left > 0) begin
                m_refr_left--;
            end else if (!m_spiking) begin
                if (v >= HI) begin
                    m_spiking = 1;
                    m_onset   = m_ts;
                    m_peak    = v;
                    m_pulse   = 1;
                end
            end else if (v <= LO) begin
                push        = 1;
                e           = '{ts: m_onset, peak: m_peak};
                m_spiking   = 0;
                m_refr_left = REFRAC;
            end else if (v > m_peak) begin
                m_peak = v;
            end
        end
        if (pop) void'(q.pop_front());
        if (push && full && !pop) m_ovf = 1;
        else if (ovf_clear)       m_ovf = 0;
        if (push && (!full || pop)) q.push_back(e);
        if (ts_clear)  m_ts = 0;
        else if (en)   m_ts = (m_ts + 1) % (64'sd1 << TS_W);
    endtask

    task automatic compare_outputs();
        bit ne;
        ne = (q.size() > 0);
        check("valid",  spk_valid,   ne);
        check("count",  fifo_count,  q.size());
        check("ovf",    overflow,    m_ovf);
        check("pulse",  spike_pulse, m_pulse);
        check("ts",     spk_ts,      ne ? q[0].ts : 0);
        check("peak",   spk_peak,    ne ? q[0].peak : 0);
        check("ts8",    spk_ts8,     ne ? (q[0].ts % 256) : 0);
        check("count8", fifo_count8, q.size());
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
        if (spike_pulse) pulse_count++;
    endtask

    task automatic hold(input int v, input int n);
        v_in = 16'(v);
        repeat (n) tick();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_valid", spk_valid,   0);
        check("rst_count", fifo_count,  0);
        check("rst_ovf",   overflow,    0);
        check("rst_pulse", spike_pulse, 0);
        check("rst_ts",    spk_ts,      0);
        check("rst_peak",  spk_peak,    0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; en = 1'b1; ts_clear = 1'b0; spk_ready = 1'b1; ovf_clear = 1'b0;
        v_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset mid-spike, then rearm guard against a high start
        hold(-3000, 2);
        hold(3000, 2);
        do_reset();
        pulse_count = 0;
        hold(3072, 10);
        check("rearm_no_spike", pulse_count, 0);
        hold(-2048, 1);
        hold(3072, 1);
        check("rearm_spike", pulse_count, 1);
        hold(-3000, 1);
        hold(0, REFRAC);

        // Single spike with onset at ts=100
        ts_clear = 1'b1; v_in = -16'sd4096; tick(); ts_clear = 1'b0;
        hold(-4096, 98);
        hold(-1000, 1);
        hold(1000, 1);
        pulse_count = 0;
        hold(2048, 1);
        hold(4000, 1);
        hold(6000, 1);
        hold(5000, 1);
        hold(-3000, 1);
        check("t2_pulse", pulse_count, 1);
        check("t2_ts",    spk_ts,      100);
        check("t2_peak",  spk_peak,    6000);
        hold(0, REFRAC);

        // Hysteresis on both thresholds
        pulse_count = 0;
        hold(2047, 1);
        hold(2048, 1);
        hold(0, 1);
        hold(2100, 1);
        for (int i = 0; i < 10; i++) hold(-int'($urandom_range(0, 2047)), 1);
        check("t3_one_onset", pulse_count, 1);
        check("t3_no_release", fifo_count, 0);
        hold(-2048, 1);
        check("t3_release", fifo_count, 1);
        check("t3_peak",    spk_peak,   2100);

        // Refractory: early re-crossing ignored, later one accepted
        pulse_count = 0;
        hold(0, 4);
        hold(3000, 2);
        hold(0, 13);
        check("t4_refrac_ignore", pulse_count, 0);
        hold(3000, 1);
        check("t4_second_onset", pulse_count, 1);
        hold(-3000, 1);
        hold(0, REFRAC);

        // Overflow with a stalled consumer
        spk_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            hold(2500 + 100 * i, 1);
            hold(-3000, 1);
            hold(0, REFRAC);
        end
        check("t5_full", fifo_count, 8);
        check("t5_ovf",  overflow,   1);
        hold(3500, 1);
        spk_ready = 1'b1;
        hold(-3000, 1);
        spk_ready = 1'b0;
        check("t5_pushpop_count", fifo_count, 8);
        check("t5_pushpop_ovf",   overflow,   1);
        hold(0, REFRAC);
        ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
        check("t5_ovf_clear", overflow, 0);
        spk_ready = 1'b1;
        hold(0, 10);

        // Timestamp wrap on the narrow counter and en freeze mid-spike
        hold(0, 300);
        hold(3000, 1);
        en = 1'b0;
        hold(-3000, 10);
        en = 1'b1;
        hold(5000, 1);
        hold(-3000, 1);
        check("t6_peak", spk_peak, 5000);
        hold(0, REFRAC);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            spk_ready = ($urandom_range(0, 1) != 0);
            ts_clear  = ($urandom_range(0, 99) == 0);
            ovf_clear = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 2) == 0)
                v_in = 16'(int'($urandom_range(0, 10000)) - 5000);
            tick();
            if (i == 1200) do_reset();
        end
        en = 1'b1; ts_clear = 1'b0; ovf_clear = 1'b0; spk_ready = 1'b1;
        hold(0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
